// File: rtl/stq_ring.sv
// Store-queue ring buffer: allocation at tail, in-order commit, drain of committed
// stores to the D$ at head, with branch-mask kill and full flush of speculative entries.
module stq_ring #(
    parameter int  DEPTH = 8,
    parameter int  XLEN  = 64,
    parameter int  MASKW = 12,
    localparam int IW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             alloc_valid,
    input  logic [MASKW-1:0] alloc_brmask,
    output logic             alloc_ready,
    output logic [IW-1:0]    alloc_idx,
    input  logic             addr_valid,
    input  logic [IW-1:0]    addr_idx,
    input  logic [XLEN-1:0]  addr,
    input  logic             data_valid,
    input  logic [IW-1:0]    data_idx,
    input  logic [XLEN-1:0]  data,
    input  logic             commit_valid,
    input  logic             br_valid,
    input  logic             br_mispredict,
    input  logic [MASKW-1:0] br_resolve_mask,
    input  logic [MASKW-1:0] br_mispredict_mask,
    input  logic             flush,
    output logic             dc_req_valid,
    input  logic             dc_req_ready,
    output logic [XLEN-1:0]  dc_req_addr,
    output logic [XLEN-1:0]  dc_req_data,
    output logic [IW:0]      count,
    output logic             full,
    output logic             empty
);
    typedef logic [IW:0] ptr_t;

    ptr_t             head_q, head_d, commit_q, commit_d, tail_q, tail_d;
    logic [DEPTH-1:0] valid_q, valid_d, cmt_q, cmt_d, av_q, av_d, dv_q, dv_d;
    logic [MASKW-1:0] mask_q [DEPTH];
    logic [MASKW-1:0] mask_d [DEPTH];
    logic [XLEN-1:0]  addr_q [DEPTH];
    logic [XLEN-1:0]  addr_d [DEPTH];
    logic [XLEN-1:0]  data_q [DEPTH];
    logic [XLEN-1:0]  data_d [DEPTH];

    logic             mispredict_s, commit_fire_s, alloc_fire_s, pop_s, kill_found_s;
    logic [MASKW-1:0] alloc_mask_s;
    logic [DEPTH-1:0] kill_vec_s;
    ptr_t             unc_cnt_s, kill_ptr_s, kill_off_s;

    function automatic logic [IW-1:0] slot(input ptr_t p);
        return p[IW-1:0];
    endfunction

    // Age of a physical slot relative to a base pointer, within one lap of the ring
    function automatic ptr_t age_of(input logic [IW-1:0] idx, input ptr_t base);
        return {1'b0, idx - base[IW-1:0]};
    endfunction

    // Occupancy, allocation and drain outputs straight from the current state
    always_comb begin
        count        = tail_q - head_q;
        full         = (count == ptr_t'(DEPTH));
        empty        = (count == ptr_t'(0));
        mispredict_s = br_valid && br_mispredict;
        alloc_ready  = !full && !flush && !mispredict_s;
        alloc_idx    = slot(tail_q);
        dc_req_valid = (head_q != commit_q) && valid_q[slot(head_q)]
                       && av_q[slot(head_q)] && dv_q[slot(head_q)];
        dc_req_addr  = addr_q[slot(head_q)];
        dc_req_data  = data_q[slot(head_q)];
    end

    // Head and commit pointer advance plus allocation qualifiers
    always_comb begin
        commit_fire_s = commit_valid && (commit_q != tail_q);
        commit_d      = commit_q + {{IW{1'b0}}, commit_fire_s};
        pop_s         = dc_req_valid && dc_req_ready;
        head_d        = head_q + {{IW{1'b0}}, pop_s};
        alloc_fire_s  = alloc_valid && alloc_ready;
        unc_cnt_s     = tail_d_base();
        if (br_valid) begin
            alloc_mask_s = alloc_brmask & ~br_resolve_mask;
        end else begin
            alloc_mask_s = alloc_brmask;
        end
    end

    function automatic ptr_t tail_d_base();
        return tail_q - (commit_q + {{IW{1'b0}}, commit_valid && (commit_q != tail_q)});
    endfunction

    // Oldest still-speculative entry hit by the mispredict mask; scanning young-to-old
    // so the last hit wins. Masks are taken before this cycle's resolve clears bits.
    always_comb begin
        kill_found_s = 1'b0;
        kill_ptr_s   = tail_q;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if ((ptr_t'(i) < unc_cnt_s)
                && ((mask_q[slot(commit_d + ptr_t'(i))] & br_mispredict_mask) != {MASKW{1'b0}})) begin
                kill_found_s = 1'b1;
                kill_ptr_s   = commit_d + ptr_t'(i);
            end else begin
                kill_found_s = kill_found_s;
                kill_ptr_s   = kill_ptr_s;
            end
        end
        kill_off_s = kill_ptr_s - commit_d;
    end

    // Per-slot kill: everything uncommitted on flush, or the young tail from the hit on mispredict
    always_comb begin
        kill_vec_s = {DEPTH{1'b0}};
        for (int i = 0; i < DEPTH; i++) begin
            if (age_of(IW'(i), commit_d) < unc_cnt_s) begin
                kill_vec_s[i] = flush || (mispredict_s && kill_found_s
                                && (age_of(IW'(i), commit_d) >= kill_off_s));
            end else begin
                kill_vec_s[i] = 1'b0;
            end
        end
    end

    // Tail pointer: flush beats mispredict beats allocate
    always_comb begin
        if (flush) begin
            tail_d = commit_d;
        end else if (mispredict_s && kill_found_s) begin
            tail_d = kill_ptr_s;
        end else if (alloc_fire_s) begin
            tail_d = tail_q + ptr_t'(1);
        end else begin
            tail_d = tail_q;
        end
    end

    // Entry array next state
    always_comb begin
        valid_d = valid_q;
        cmt_d   = cmt_q;
        av_d    = av_q;
        dv_d    = dv_q;
        mask_d  = mask_q;
        addr_d  = addr_q;
        data_d  = data_q;
        for (int i = 0; i < DEPTH; i++) begin
            if (alloc_fire_s && (slot(tail_q) == IW'(i))) begin
                valid_d[i] = 1'b1;
                cmt_d[i]   = 1'b0;
                av_d[i]    = 1'b0;
                dv_d[i]    = 1'b0;
                mask_d[i]  = alloc_mask_s;
            end else if (kill_vec_s[i] || (pop_s && (slot(head_q) == IW'(i)))) begin
                valid_d[i] = 1'b0;
                cmt_d[i]   = 1'b0;
                av_d[i]    = 1'b0;
                dv_d[i]    = 1'b0;
            end else begin
                cmt_d[i] = cmt_q[i] | (commit_fire_s && (slot(commit_q) == IW'(i)));
                if (br_valid && valid_q[i] && !cmt_q[i]) begin
                    mask_d[i] = mask_q[i] & ~br_resolve_mask;
                end else begin
                    mask_d[i] = mask_q[i];
                end
                if (addr_valid && (addr_idx == IW'(i)) && valid_q[i]) begin
                    addr_d[i] = addr;
                    av_d[i]   = 1'b1;
                end else begin
                    addr_d[i] = addr_q[i];
                    av_d[i]   = av_q[i];
                end
                if (data_valid && (data_idx == IW'(i)) && valid_q[i]) begin
                    data_d[i] = data;
                    dv_d[i]   = 1'b1;
                end else begin
                    data_d[i] = data_q[i];
                    dv_d[i]   = dv_q[i];
                end
            end
        end
    end

    // State registers; reset clears every pointer, flag and payload
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q   <= {(IW+1){1'b0}};
            commit_q <= {(IW+1){1'b0}};
            tail_q   <= {(IW+1){1'b0}};
            valid_q  <= {DEPTH{1'b0}};
            cmt_q    <= {DEPTH{1'b0}};
            av_q     <= {DEPTH{1'b0}};
            dv_q     <= {DEPTH{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                mask_q[i] <= {MASKW{1'b0}};
                addr_q[i] <= {XLEN{1'b0}};
                data_q[i] <= {XLEN{1'b0}};
            end
        end else begin
            head_q   <= head_d;
            commit_q <= commit_d;
            tail_q   <= tail_d;
            valid_q  <= valid_d;
            cmt_q    <= cmt_d;
            av_q     <= av_d;
            dv_q     <= dv_d;
            mask_q   <= mask_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
        end
    end

endmodule

// File: tb/tb_stq_ring.sv
// Bench for stq_ring (DEPTH=4): directed scenarios plus random traffic, all checked
// against an age-ordered queue model of the store queue.
module tb_stq_ring;
    localparam int DEPTH = 4;
    localparam int XLEN  = 64;
    localparam int MASKW = 12;
    localparam int IW    = 2;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             alloc_valid, alloc_ready;
    logic [MASKW-1:0] alloc_brmask;
    logic [IW-1:0]    alloc_idx, addr_idx, data_idx;
    logic             addr_valid, data_valid, commit_valid;
    logic [XLEN-1:0]  addr, data, dc_req_addr, dc_req_data;
    logic             br_valid, br_mispredict, flush;
    logic [MASKW-1:0] br_resolve_mask, br_mispredict_mask;
    logic             dc_req_valid, dc_req_ready;
    logic [IW:0]      count;
    logic             full, empty;

    always #5 clk = ~clk;

    stq_ring #(.DEPTH(DEPTH), .XLEN(XLEN), .MASKW(MASKW)) dut (
        .clk(clk), .rst(rst),
        .alloc_valid(alloc_valid), .alloc_brmask(alloc_brmask),
        .alloc_ready(alloc_ready), .alloc_idx(alloc_idx),
        .addr_valid(addr_valid), .addr_idx(addr_idx), .addr(addr),
        .data_valid(data_valid), .data_idx(data_idx), .data(data),
        .commit_valid(commit_valid),
        .br_valid(br_valid), .br_mispredict(br_mispredict),
        .br_resolve_mask(br_resolve_mask), .br_mispredict_mask(br_mispredict_mask),
        .flush(flush),
        .dc_req_valid(dc_req_valid), .dc_req_ready(dc_req_ready),
        .dc_req_addr(dc_req_addr), .dc_req_data(dc_req_data),
        .count(count), .full(full), .empty(empty)
    );

    typedef struct {
        bit               cmt;
        bit               av;
        bit               dv;
        logic [MASKW-1:0] mask;
        logic [XLEN-1:0]  addr;
        logic [XLEN-1:0]  data;
    } ent_t;

    ent_t mq[$];
    int   head_m = 0;
    int   n_cmp  = 0;
    int   n_bad  = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic idle();
        alloc_valid = 1'b0; alloc_brmask = 12'h000;
        addr_valid = 1'b0; addr_idx = 2'd0; addr = 64'd0;
        data_valid = 1'b0; data_idx = 2'd0; data = 64'd0;
        commit_valid = 1'b0; br_valid = 1'b0; br_mispredict = 1'b0;
        br_resolve_mask = 12'h000; br_mispredict_mask = 12'h000;
        flush = 1'b0; dc_req_ready = 1'b0;
    endtask

    function automatic bit model_dcv();
        if (mq.size() == 0) return 1'b0;
        return mq[0].cmt && mq[0].av && mq[0].dv;
    endfunction

    task automatic check_outputs();
        int n = mq.size();
        check_eq("count", 64'(count), 64'(n));
        check_eq("full", 64'(full), 64'(n == DEPTH));
        check_eq("empty", 64'(empty), 64'(n == 0));
        check_eq("alloc_ready", 64'(alloc_ready),
                 64'((n < DEPTH) && !flush && !(br_valid && br_mispredict)));
        check_eq("alloc_idx", 64'(alloc_idx), 64'((head_m + n) % DEPTH));
        check_eq("dc_req_valid", 64'(dc_req_valid), 64'(model_dcv()));
        if (model_dcv()) begin
            check_eq("dc_req_addr", dc_req_addr, mq[0].addr);
            check_eq("dc_req_data", dc_req_data, mq[0].data);
        end
    endtask

    // Apply one clock edge of the current inputs to the model
    task automatic model_step();
        int   n = mq.size();
        int   ncmt = 0;
        int   first_unc, kill_at, k;
        bit   dcv = model_dcv();
        bit   ok  = (n < DEPTH) && !flush && !(br_valid && br_mispredict);
        ent_t e;
        for (int j = 0; j < n; j++) if (mq[j].cmt) ncmt++;
        k = (int'(addr_idx) - head_m + DEPTH) % DEPTH;
        if (addr_valid && k < n) begin mq[k].addr = addr; mq[k].av = 1'b1; end
        k = (int'(data_idx) - head_m + DEPTH) % DEPTH;
        if (data_valid && k < n) begin mq[k].data = data; mq[k].dv = 1'b1; end
        first_unc = ncmt + ((commit_valid && ncmt < n) ? 1 : 0);
        kill_at = -1;
        if (br_valid && br_mispredict)
            for (int j = first_unc; j < n; j++)
                if (kill_at < 0 && (mq[j].mask & br_mispredict_mask) != 12'h000) kill_at = j;
        if (br_valid)
            for (int j = ncmt; j < n; j++) mq[j].mask = mq[j].mask & ~br_resolve_mask;
        if (commit_valid && ncmt < n) mq[ncmt].cmt = 1'b1;
        if (flush) begin
            while (mq.size() > first_unc) void'(mq.pop_back());
        end else if (kill_at >= 0) begin
            while (mq.size() > kill_at) void'(mq.pop_back());
        end
        if (alloc_valid && ok) begin
            e.cmt = 1'b0; e.av = 1'b0; e.dv = 1'b0;
            e.mask = br_valid ? (alloc_brmask & ~br_resolve_mask) : alloc_brmask;
            e.addr = 64'd0; e.data = 64'd0;
            mq.push_back(e);
        end
        if (dcv && dc_req_ready) begin
            void'(mq.pop_front());
            head_m = (head_m + 1) % DEPTH;
        end
    endtask

    // Called just after a falling edge with inputs already driven
    task automatic run_cycle();
        #1;
        check_outputs();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        #1;
        check_eq("rst_count", 64'(count), 64'd0);
        check_eq("rst_empty", 64'(empty), 64'd1);
        check_eq("rst_full", 64'(full), 64'd0);
        check_eq("rst_alloc_ready", 64'(alloc_ready), 64'd1);
        check_eq("rst_dc_valid", 64'(dc_req_valid), 64'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        mq.delete();
        head_m = 0;
    endtask

    task automatic alloc_one(input logic [MASKW-1:0] m);
        idle();
        alloc_valid = 1'b1;
        alloc_brmask = m;
        run_cycle();
    endtask

    task automatic write_commit(input logic [IW-1:0] idx, input logic [XLEN-1:0] a,
                                input logic [XLEN-1:0] d, input logic cm, input logic rdy);
        idle();
        addr_valid = 1'b1; addr_idx = idx; addr = a;
        data_valid = 1'b1; data_idx = idx; data = d;
        commit_valid = cm;
        dc_req_ready = rdy;
        run_cycle();
    endtask

    logic [MASKW-1:0] mp_masks [4] = '{12'h000, 12'h001, 12'h002, 12'h002};

    initial begin
        idle();
        @(negedge clk);
        do_reset();

        // Fill to capacity; the fifth request must bounce
        for (int i = 0; i < 5; i++) begin
            idle();
            alloc_valid = 1'b1;
            #1;
            if (i < 4) check_eq("fill_idx", 64'(alloc_idx), 64'(i));
            else       check_eq("fill_ready5", 64'(alloc_ready), 64'd0);
            run_cycle();
        end
        idle(); #1;
        check_eq("fill_count", 64'(count), 64'd4);
        check_eq("fill_full", 64'(full), 64'd1);
        idle(); flush = 1'b1; run_cycle();

        // Drain with back-pressure
        alloc_one(12'h000);
        write_commit(2'd0, 64'h80, 64'h1234, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            idle(); #1;
            check_eq("drain_valid", 64'(dc_req_valid), 64'd1);
            check_eq("drain_addr", dc_req_addr, 64'h80);
            check_eq("drain_data", dc_req_data, 64'h1234);
            run_cycle();
        end
        idle(); dc_req_ready = 1'b1; run_cycle();
        idle(); #1;
        check_eq("drain_empty", 64'(empty), 64'd1);

        // Wrap: index sequence 0,1,2,3,0,1 with at most one entry resident
        do_reset();
        for (int i = 0; i < 6; i++) begin
            idle(); alloc_valid = 1'b1; #1;
            check_eq("wrap_idx", 64'(alloc_idx), 64'(i % 4));
            run_cycle();
            write_commit(IW'(i % 4), {$urandom, $urandom}, {$urandom, $urandom}, 1'b1, 1'b0);
            idle(); dc_req_ready = 1'b1; #1;
            check_eq("wrap_cnt_le1", 64'(count <= 3'd1), 64'd1);
            run_cycle();
        end

        // Mispredict kills the two youngest entries
        do_reset();
        for (int i = 0; i < 4; i++) alloc_one(mp_masks[i]);
        idle(); commit_valid = 1'b1; run_cycle();
        idle(); br_valid = 1'b1; br_mispredict = 1'b1; br_mispredict_mask = 12'h002;
        alloc_valid = 1'b1; #1;
        check_eq("mp_alloc_blocked", 64'(alloc_ready), 64'd0);
        run_cycle();
        idle(); #1;
        check_eq("mp_count", 64'(count), 64'd2);
        check_eq("mp_tail", 64'(alloc_idx), 64'd2);

        // Flush keeps the committed entry, which still drains
        do_reset();
        for (int i = 0; i < 3; i++) alloc_one(12'h000);
        write_commit(2'd0, 64'hA0, 64'h55, 1'b1, 1'b0);
        idle(); flush = 1'b1; run_cycle();
        idle(); #1;
        check_eq("flush_count", 64'(count), 64'd1);
        check_eq("flush_tail", 64'(alloc_idx), 64'd1);
        idle(); dc_req_ready = 1'b1; run_cycle();
        idle(); #1;
        check_eq("flush_drained", 64'(empty), 64'd1);

        // Asynchronous reset between edges with a pending drain request
        do_reset();
        for (int i = 0; i < 3; i++) alloc_one(12'h000);
        write_commit(2'd0, 64'hBEEF, 64'hCAFE, 1'b1, 1'b0);
        idle(); #1;
        check_eq("ar_pre_count", 64'(count), 64'd3);
        check_eq("ar_pre_dcv", 64'(dc_req_valid), 64'd1);
        rst = 1'b1; #1;
        check_eq("ar_count", 64'(count), 64'd0);
        check_eq("ar_dcv", 64'(dc_req_valid), 64'd0);
        @(posedge clk); @(negedge clk);
        rst = 1'b0; mq.delete(); head_m = 0;

        // Random traffic
        for (int c = 0; c < 3000; c++) begin
            idle();
            alloc_valid  = ($urandom_range(0, 99) < 60);
            alloc_brmask = ($urandom_range(0, 3) == 0) ? 12'h000 : 12'(1 << $urandom_range(0, 3));
            addr_valid   = ($urandom_range(0, 1) == 1);
            addr_idx     = IW'($urandom_range(0, 3));
            addr         = {$urandom, $urandom};
            data_valid   = ($urandom_range(0, 1) == 1);
            data_idx     = IW'($urandom_range(0, 3));
            data         = {$urandom, $urandom};
            commit_valid = ($urandom_range(0, 99) < 40);
            br_valid     = ($urandom_range(0, 99) < 20);
            br_mispredict = br_valid && ($urandom_range(0, 99) < 25);
            br_resolve_mask    = 12'($urandom_range(0, 15));
            br_mispredict_mask = 12'(1 << $urandom_range(0, 3));
            flush        = ($urandom_range(0, 99) < 3);
            dc_req_ready = ($urandom_range(0, 99) < 60);
            run_cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/stq_ring.md
STQ_RING -- requirements
Module: stq_ring

Interface
REQ-001 SHALL have parameter DEPTH, default 8, store-queue entries (power of two, >=2).
REQ-002 SHALL have parameter XLEN, default 64, address/data width.
REQ-003 SHALL have parameter MASKW, default 12, branch-mask width.
REQ-004 SHALL have ports (IW = log2 DEPTH):
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- alloc_valid  in  1  allocate one store at tail
- alloc_brmask  in  MASKW  branch mask of the allocating store
- alloc_ready  out  1  entry available
- alloc_idx  out  IW  index that will be given to the store
- addr_valid / addr_idx / addr  in  1/IW/XLEN  address write for an entry
- data_valid / data_idx / data  in  1/IW/XLEN  data write for an entry
- commit_valid  in  1  ROB commits the oldest uncommitted store
- br_valid  in  1  branch update valid
- br_mispredict  in  1  mispredict qualifier
- br_resolve_mask  in  MASKW  bits to clear from every entry mask
- br_mispredict_mask  in  MASKW  kill entries with any matching bit
- flush  in  1  discard all uncommitted entries
- dc_req_valid / dc_req_ready  out/in  1/1  drain handshake to D$
- dc_req_addr / dc_req_data  out  XLEN/XLEN  head entry payload
- count  out  IW+1  occupied entries
- full / empty  out  1/1  count==DEPTH / count==0

Function
REQ-005 SHALL keep head, commit and tail pointers, each IW+1 bits (extra wrap bit); ordering is head <= commit <= tail modulo 2^(IW+1).
REQ-006 SHALL compute count = tail - head (IW+1-bit wraparound); full/empty derive combinationally from count.
REQ-007 SHALL drive alloc_ready = !full && !flush && !(br_valid && br_mispredict); alloc_idx = tail[IW-1:0].
REQ-008 On alloc_valid && alloc_ready SHALL write the tail entry (valid=1, addr_valid=0, data_valid=0, committed=0, brmask = alloc_brmask & ~resolve when br_valid) and increment tail.
REQ-009 SHALL ignore alloc_valid when alloc_ready is 0; no bypass: a same-cycle pop does not free a slot for a same-cycle allocation.
REQ-010 addr_valid SHALL write addr and set addr_valid of entry addr_idx; data path likewise; writes to invalid entries SHALL be ignored.
REQ-011 commit_valid SHALL set committed on entry commit and increment commit; ignored when commit == tail.
REQ-012 dc_req_valid SHALL be asserted when head != commit and the head entry has addr_valid and data_valid; dc_req_addr/data SHALL present the head entry.
REQ-013 dc_req_valid && dc_req_ready SHALL invalidate the head entry and increment head; dc_req_valid SHALL not drop until accepted.
REQ-014 br_valid SHALL clear br_resolve_mask bits from every valid uncommitted entry mask.
REQ-015 br_valid && br_mispredict SHALL invalidate every uncommitted entry whose mask & br_mispredict_mask != 0, and set tail to the oldest such index (killed entries are contiguous and youngest); if none match, tail is unchanged.
REQ-016 flush SHALL invalidate all uncommitted entries and set tail = commit; committed entries are retained and still drain.
REQ-017 Priority: flush > mispredict > allocate for tail; commit, address/data writes to surviving entries and drain pop proceed in the same cycle.
REQ-018 Committed entries SHALL never be killed by mispredict or flush.

Reset
REQ-019 On rst assertion, immediately and independent of clk: head=commit=tail=0, all entry valid/committed/addr_valid/data_valid=0, count=0, empty=1, full=0, alloc_ready=1, dc_req_valid=0.
REQ-020 Reset mid-drain SHALL abandon the outstanding request without completing it; no state survives reset.

Verification (DEPTH=4)
REQ-021 Fill: 4 allocations -> alloc_idx 0,1,2,3; full=1, alloc_ready=0; 5th alloc_valid ignored, count stays 4.
REQ-022 Drain: alloc idx0, addr=0x80, data=0x1234, commit -> next cycle dc_req_valid=1, addr 0x80, data 0x1234; with dc_req_ready=0 for 3 cycles, held stable; accepted -> empty=1.
REQ-023 Wrap: 6 allocate/commit/drain cycles -> indices 0,1,2,3,0,1; count never exceeds 1; pointer wrap bit toggles.
REQ-024 Mispredict: entries 0..3 with masks 0x000,0x001,0x002,0x002; entry 0 committed; br_mispredict_mask=0x002 -> entries 2,3 killed, tail idx=2, count=2; same-cycle alloc_valid ignored.
REQ-025 Flush vs commit: 3 entries, entry 0 committed, flush -> tail=commit=1, count=1; entry 0 still drains.
REQ-026 Async reset: rst asserted between edges with count=3 and dc_req_valid=1 -> count=0, dc_req_valid=0 before the next clk edge.
